hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline interlock controller for the 5-stage core; sits beside the forwarding unit.
//  Sequences stalls and flushes for three hazards that forwarding cannot cover:
//   - load-use hazards;
//   - taken-branch redirects;
//   - multi-cycle EX operations.
//  Drives the hold, bubble and flush strobes of the FD, DE and EM pipeline registers and the PC.
//  Keeps stall and flush performance counters.
// PARAMETERS
//  CNT_W       16  width of stall_cnt / flush_cnt (saturating)
//  BR_PENALTY  1   cycles FD is flushed after a taken branch (1..3)
//  MC_TIMEOUT  64  max cycles in MC_WAIT before forced release
// PORTS
//  clk            in   1      rising-edge clock
//  rst            in   1      synchronous, active-high reset
//  fd_rs1         in   5      rs1 of instruction in FD
//  fd_rs2         in   5      rs2 of instruction in FD
//  fd_uses_rs1    in   1      FD instruction reads rs1
//  fd_uses_rs2    in   1      FD instruction reads rs2
//  de_ctrl_memrd  in   1      DE instruction is a load
//  de_ctrl_regwr  in   1      DE instruction writes a register
//  de_wr_reg      in   6      DE destination register
//  ex_br_taken    in   1      branch in EX resolved taken (1-cycle pulse)
//  ex_mc_start    in   1      multi-cycle op launched in EX (1-cycle pulse)
//  ex_mc_done     in   1      multi-cycle result valid
//  pc_hold        out  1      PC keeps its value
//  fd_hold        out  1      FD register keeps its value
//  fd_flush       out  1      FD register loads a NOP
//  de_hold        out  1      DE register keeps its value
//  de_bubble      out  1      DE register loads a NOP
//  em_bubble      out  1      EM register loads a NOP
//  mc_timeout     out  1      sticky; set on MC_TIMEOUT expiry, cleared only by rst
//  stall_cnt      out  CNT_W  cycles with pc_hold=1
//  flush_cnt      out  CNT_W  cycles with fd_flush=1
// BEHAVIOUR
//  Reset:
//   - While rst=1 all strobe outputs are 0.
//   - Next edge: state=RUN, both counters=0, mc_timeout=0, internal counters=0.
//  Timing:
//   - Strobes are combinational from the current state and current inputs (0-cycle latency).
//   - State, counters and flags are updated on the clock edge.
//  Load-use term LU (6-bit compare on de_wr_reg):
//   - LU = de_ctrl_memrd & de_ctrl_regwr & de_wr_reg!=0 & ((fd_uses_rs1 & de_wr_reg=={1'b0,fd_rs1})
//          | (fd_uses_rs2 & de_wr_reg=={1'b0,fd_rs2})).
//  RUN, evaluated in priority order:
//   - ex_br_taken: fd_flush=1, de_bubble=1.
//     If BR_PENALTY>1, go to FLUSH with rem=BR_PENALTY-1; otherwise stay in RUN.
//   - elif ex_mc_start: pc_hold=fd_hold=de_hold=em_bubble=1 this cycle; go to MC_WAIT, tmo=0.
//   - elif LU: pc_hold=fd_hold=1, de_bubble=1 for exactly one cycle; stay in RUN.
//   - else: all strobes 0.
//  FLUSH:
//   - fd_flush=1, de_bubble=1; rem decrements each cycle; at rem==1 go to RUN.
//   - LU is ignored because FD holds a wrong-path instruction.
//   - ex_br_taken and ex_mc_start are ignored (both are invalid while flushing).
//  MC_WAIT:
//   - pc_hold=fd_hold=de_hold=em_bubble=1; tmo increments each cycle.
//   - ex_mc_done=1: all strobes 0 in that same cycle; go to RUN.
//   - tmo==MC_TIMEOUT-1 without done: strobes 0, set mc_timeout, go to RUN.
//   - ex_br_taken is ignored.
//  Counters:
//   - stall_cnt +1 on every cycle with pc_hold=1; flush_cnt +1 on every cycle with fd_flush=1.
//   - Both saturate at all-ones and never wrap.
//  Reset mid-operation: any state is abandoned immediately; no pending flush or stall survives rst.
// TESTING
//  1. Load x5 in DE, FD reads rs1=5 with uses=1.
//     -> exactly 1 cycle of pc_hold=fd_hold=de_bubble=1; stall_cnt=1.
//  2. Load with de_wr_reg=0 and fd_rs1=0, and load with de_wr_reg=6'd37 and fd_rs1=5.
//     -> no stall in either case.
//  3. BR_PENALTY=2, ex_br_taken pulse.
//     -> fd_flush=1 for 2 consecutive cycles; flush_cnt=2; a load-use in the 2nd cycle gives no stall.
//  4. ex_mc_start, then ex_mc_done 7 cycles later.
//     -> hold strobes =1 for 8 cycles (start cycle + 7 waiting cycles), 0 in the done cycle; stall_cnt=8.
//  5. MC_TIMEOUT=4, ex_mc_start, done never arrives.
//     -> release after 4 cycles in MC_WAIT; mc_timeout=1 and stays 1 until rst.
//  6. ex_br_taken, ex_mc_start and LU all in the same cycle.
//     -> branch wins: fd_flush=1, pc_hold=0. Then rst asserted during MC_WAIT -> strobes 0, state RUN, counters 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline interlock controller: stalls and flushes for load-use, taken-branch and
// multi-cycle EX hazards, plus saturating stall/flush performance counters.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_RUN     | normal issue; resolves branch > multi-cycle start > load-use
// ST_FLUSH   | extra branch-penalty cycles; FD holds wrong-path instructions
// ST_MC_WAIT | multi-cycle EX op in flight; front end frozen until done/timeout
module hazard_ctrl #(
  parameter int CNT_W      = 16,
  parameter int BR_PENALTY = 1,
  parameter int MC_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       fd_rs1,
  input  logic [4:0]       fd_rs2,
  input  logic             fd_uses_rs1,
  input  logic             fd_uses_rs2,
  input  logic             de_ctrl_memrd,
  input  logic             de_ctrl_regwr,
  input  logic [5:0]       de_wr_reg,
  input  logic             ex_br_taken,
  input  logic             ex_mc_start,
  input  logic             ex_mc_done,
  output logic             pc_hold,
  output logic             fd_hold,
  output logic             fd_flush,
  output logic             de_hold,
  output logic             de_bubble,
  output logic             em_bubble,
  output logic             mc_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_MC_WAIT = 2'd2
  } state_t;

  localparam int TMO_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MC_TIMEOUT - 1);
  localparam logic [1:0] REM_INIT = 2'(BR_PENALTY - 1);
  localparam bit BR_MULTI = (BR_PENALTY > 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic [1:0]       rem;
  logic [TMO_W-1:0] tmo;
  logic             lu;
  logic             mc_release;

  // de_wr_reg is 6 bits wide; registers 32..63 can never alias an FD source.
  always_comb begin
    lu = de_ctrl_memrd && de_ctrl_regwr && (de_wr_reg != 6'd0) &&
         ((fd_uses_rs1 && (de_wr_reg == {1'b0, fd_rs1})) ||
          (fd_uses_rs2 && (de_wr_reg == {1'b0, fd_rs2})));
  end

  assign mc_release = ex_mc_done || (tmo == TMO_LAST);

  always_comb begin
    pc_hold   = 1'b0;
    fd_hold   = 1'b0;
    fd_flush  = 1'b0;
    de_hold   = 1'b0;
    de_bubble = 1'b0;
    em_bubble = 1'b0;
    if (!rst) begin
      case (state)
        ST_RUN: begin
          if (ex_br_taken) begin
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
          end else if (ex_mc_start) begin
            pc_hold   = 1'b1;
            fd_hold   = 1'b1;
            de_hold   = 1'b1;
            em_bubble = 1'b1;
          end else if (lu) begin
            pc_hold   = 1'b1;
            fd_hold   = 1'b1;
            de_bubble = 1'b1;
          end
        end
        ST_FLUSH: begin
          fd_flush  = 1'b1;
          de_bubble = 1'b1;
        end
        ST_MC_WAIT: begin
          if (!mc_release) begin
            pc_hold   = 1'b1;
            fd_hold   = 1'b1;
            de_hold   = 1'b1;
            em_bubble = 1'b1;
          end
        end
        default: begin
          pc_hold = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      rem        <= 2'd0;
      tmo        <= '0;
      mc_timeout <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (ex_br_taken) begin
            if (BR_MULTI) begin
              state <= ST_FLUSH;
              rem   <= REM_INIT;
            end
          end else if (ex_mc_start) begin
            state <= ST_MC_WAIT;
            tmo   <= '0;
          end
        end
        ST_FLUSH: begin
          if (rem <= 2'd1) begin
            state <= ST_RUN;
            rem   <= 2'd0;
          end else begin
            rem <= rem - 1'b1;
          end
        end
        ST_MC_WAIT: begin
          if (ex_mc_done) begin
            state <= ST_RUN;
            tmo   <= '0;
          end else if (tmo == TMO_LAST) begin
            state      <= ST_RUN;
            tmo        <= '0;
            mc_timeout <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        default: begin
          state <= ST_RUN;
        end
      endcase

      if (pc_hold && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (fd_flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two configurations driven in parallel, checked every cycle
// against an integer-based reference model, plus directed scenario checks.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] fd_rs1, fd_rs2;
  logic       fd_uses_rs1, fd_uses_rs2;
  logic       de_ctrl_memrd, de_ctrl_regwr;
  logic [5:0] de_wr_reg;
  logic       ex_br_taken, ex_mc_start, ex_mc_done;

  logic        a_pc_hold, a_fd_hold, a_fd_flush, a_de_hold, a_de_bubble, a_em_bubble, a_mc_timeout;
  logic [3:0]  a_stall_cnt, a_flush_cnt;
  logic        b_pc_hold, b_fd_hold, b_fd_flush, b_de_hold, b_de_bubble, b_em_bubble, b_mc_timeout;
  logic [15:0] b_stall_cnt, b_flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(4), .BR_PENALTY(2), .MC_TIMEOUT(4)) u_a (
    .clk(clk), .rst(rst), .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
    .fd_uses_rs1(fd_uses_rs1), .fd_uses_rs2(fd_uses_rs2),
    .de_ctrl_memrd(de_ctrl_memrd), .de_ctrl_regwr(de_ctrl_regwr), .de_wr_reg(de_wr_reg),
    .ex_br_taken(ex_br_taken), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
    .pc_hold(a_pc_hold), .fd_hold(a_fd_hold), .fd_flush(a_fd_flush), .de_hold(a_de_hold),
    .de_bubble(a_de_bubble), .em_bubble(a_em_bubble), .mc_timeout(a_mc_timeout),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt));

  hazard_ctrl #(.CNT_W(16), .BR_PENALTY(3), .MC_TIMEOUT(16)) u_b (
    .clk(clk), .rst(rst), .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
    .fd_uses_rs1(fd_uses_rs1), .fd_uses_rs2(fd_uses_rs2),
    .de_ctrl_memrd(de_ctrl_memrd), .de_ctrl_regwr(de_ctrl_regwr), .de_wr_reg(de_wr_reg),
    .ex_br_taken(ex_br_taken), .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
    .pc_hold(b_pc_hold), .fd_hold(b_fd_hold), .fd_flush(b_fd_flush), .de_hold(b_de_hold),
    .de_bubble(b_de_bubble), .em_bubble(b_em_bubble), .mc_timeout(b_mc_timeout),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt));

  // strobe vector order: {pc_hold, fd_hold, fd_flush, de_hold, de_bubble, em_bubble}
  localparam logic [5:0] S_NONE  = 6'b000000;
  localparam logic [5:0] S_FLUSH = 6'b001010;
  localparam logic [5:0] S_MC    = 6'b110101;
  localparam logic [5:0] S_LU    = 6'b110010;

  localparam int P_BR  [2] = '{2, 3};
  localparam int P_TMO [2] = '{4, 16};
  localparam int P_MAX [2] = '{15, 65535};

  logic [5:0]  o_str   [2];
  logic        o_tmo   [2];
  logic [15:0] o_stall [2];
  logic [15:0] o_flush [2];

  assign o_str[0]   = {a_pc_hold, a_fd_hold, a_fd_flush, a_de_hold, a_de_bubble, a_em_bubble};
  assign o_str[1]   = {b_pc_hold, b_fd_hold, b_fd_flush, b_de_hold, b_de_bubble, b_em_bubble};
  assign o_tmo[0]   = a_mc_timeout;
  assign o_tmo[1]   = b_mc_timeout;
  assign o_stall[0] = {12'd0, a_stall_cnt};
  assign o_stall[1] = b_stall_cnt;
  assign o_flush[0] = {12'd0, a_flush_cnt};
  assign o_flush[1] = b_flush_cnt;

  // reference model: flush cycles still owed, cycles spent waiting (-1 = not waiting)
  int         m_flush_left [2];
  int         m_mc         [2];
  bit         m_tmo        [2];
  int         m_stall      [2];
  int         m_flush      [2];
  logic [5:0] e_str        [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit lu_ref();
    int wr = int'(de_wr_reg);
    return de_ctrl_memrd && de_ctrl_regwr && wr != 0 &&
           ((fd_uses_rs1 && wr == int'(fd_rs1)) || (fd_uses_rs2 && wr == int'(fd_rs2)));
  endfunction

  function automatic logic [5:0] exp_strobes(input int i);
    if (rst) return S_NONE;
    if (m_flush_left[i] > 0) return S_FLUSH;
    if (m_mc[i] >= 0) return (ex_mc_done || m_mc[i] == P_TMO[i] - 1) ? S_NONE : S_MC;
    if (ex_br_taken) return S_FLUSH;
    if (ex_mc_start) return S_MC;
    if (lu_ref()) return S_LU;
    return S_NONE;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_flush_left[i] = 0;
      m_mc[i]         = -1;
      m_tmo[i]        = 1'b0;
      m_stall[i]      = 0;
      m_flush[i]      = 0;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_flush_left[i] = 0;
        m_mc[i]         = -1;
        m_tmo[i]        = 1'b0;
        m_stall[i]      = 0;
        m_flush[i]      = 0;
      end else begin
        if (e_str[i][5] && m_stall[i] < P_MAX[i]) m_stall[i]++;
        if (e_str[i][3] && m_flush[i] < P_MAX[i]) m_flush[i]++;
        if (m_flush_left[i] > 0) begin
          m_flush_left[i]--;
        end else if (m_mc[i] >= 0) begin
          if (ex_mc_done) m_mc[i] = -1;
          else if (m_mc[i] == P_TMO[i] - 1) begin
            m_mc[i]  = -1;
            m_tmo[i] = 1'b1;
          end else m_mc[i]++;
        end else if (ex_br_taken) begin
          m_flush_left[i] = P_BR[i] - 1;
        end else if (ex_mc_start) begin
          m_mc[i] = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      string n = (i == 0) ? "a" : "b";
      e_str[i] = exp_strobes(i);
      check({n, ".strobes"}, 32'(o_str[i]), 32'(e_str[i]));
      check({n, ".mc_timeout"}, 32'(o_tmo[i]), 32'(m_tmo[i]));
      check({n, ".stall_cnt"}, 32'(o_stall[i]), 32'(m_stall[i]));
      check({n, ".flush_cnt"}, 32'(o_flush[i]), 32'(m_flush[i]));
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    fd_rs1 = 5'd0; fd_rs2 = 5'd0; fd_uses_rs1 = 1'b0; fd_uses_rs2 = 1'b0;
    de_ctrl_memrd = 1'b0; de_ctrl_regwr = 1'b0; de_wr_reg = 6'd0;
    ex_br_taken = 1'b0; ex_mc_start = 1'b0; ex_mc_done = 1'b0;
  endtask

  task automatic set_load(input logic [5:0] wr, input logic [4:0] rs1);
    de_ctrl_memrd = 1'b1; de_ctrl_regwr = 1'b1; de_wr_reg = wr;
    fd_rs1 = rs1; fd_uses_rs1 = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic rand_inputs();
    de_wr_reg     = 6'($urandom_range(0, 63));
    de_ctrl_memrd = 1'($urandom_range(0, 1));
    de_ctrl_regwr = ($urandom_range(0, 3) != 0);
    fd_rs1        = 5'($urandom_range(0, 31));
    fd_rs2        = 5'($urandom_range(0, 31));
    if ($urandom_range(0, 2) == 0) fd_rs1 = de_wr_reg[4:0];
    if ($urandom_range(0, 3) == 0) fd_rs2 = de_wr_reg[4:0];
    fd_uses_rs1   = 1'($urandom_range(0, 1));
    fd_uses_rs2   = 1'($urandom_range(0, 1));
    ex_br_taken   = ($urandom_range(0, 11) == 0);
    ex_mc_start   = ($urandom_range(0, 15) == 0);
    ex_mc_done    = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // strobes stay low during reset even with every hazard present
    set_load(6'd5, 5'd5);
    ex_br_taken = 1'b1; ex_mc_start = 1'b1;
    step();
    idle_inputs();
    rst = 1'b0;
    step();

    // load-use: one stall cycle
    set_load(6'd5, 5'd5);
    step();
    idle_inputs();
    step();
    check("t1.stall_cnt", 32'(b_stall_cnt), 32'd1);

    // x0 destination and a 6-bit destination beyond the architectural file
    set_load(6'd0, 5'd0);
    step();
    set_load(6'd37, 5'd5);
    step();
    idle_inputs();
    step();
    check("t2.stall_cnt", 32'(b_stall_cnt), 32'd1);

    // taken branch followed by a load-use in the flush window
    ex_br_taken = 1'b1;
    step();
    idle_inputs();
    set_load(6'd5, 5'd5);
    step();
    idle_inputs();
    step();
    step();
    check("t3.a_flush_cnt", 32'(a_flush_cnt), 32'd2);
    check("t3.b_flush_cnt", 32'(b_flush_cnt), 32'd3);
    check("t3.stall_cnt", 32'(b_stall_cnt), 32'd1);

    // multi-cycle op: done 7 cycles after start (a times out after 4)
    do_reset();
    ex_mc_start = 1'b1;
    step();
    ex_mc_start = 1'b0;
    repeat (7) step();
    ex_mc_done = 1'b1;
    #1;
    check("t4.done_strobes", 32'(o_str[1]), 32'(S_NONE));
    step();
    ex_mc_done = 1'b0;
    step();
    check("t4.b_stall_cnt", 32'(b_stall_cnt), 32'd8);
    check("t5.a_stall_cnt", 32'(a_stall_cnt), 32'd4);
    check("t5.a_timeout", 32'(a_mc_timeout), 32'd1);
    check("t4.b_timeout", 32'(b_mc_timeout), 32'd0);
    repeat (10) step();
    check("t5.a_timeout_sticky", 32'(a_mc_timeout), 32'd1);

    // branch beats multi-cycle start and load-use in the same cycle
    do_reset();
    set_load(6'd5, 5'd5);
    ex_br_taken = 1'b1; ex_mc_start = 1'b1;
    #1;
    check("t6.pc_hold", 32'(a_pc_hold), 32'd0);
    check("t6.fd_flush", 32'(a_fd_flush), 32'd1);
    step();
    idle_inputs();
    repeat (3) step();

    // reset abandons a multi-cycle wait
    ex_mc_start = 1'b1;
    step();
    ex_mc_start = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    check("t6.rst_strobes", 32'(o_str[1]), 32'(S_NONE));
    step();
    rst = 1'b0;
    #1;
    check("t6.post_rst_strobes", 32'(o_str[1]), 32'(S_NONE));
    check("t6.post_rst_stall", 32'(b_stall_cnt), 32'd0);
    check("t6.post_rst_flush", 32'(b_flush_cnt), 32'd0);
    check("t6.post_rst_tmo", 32'(a_mc_timeout), 32'd0);
    step();

    // randomized traffic with occasional resets; a's 4-bit counters saturate
    for (int k = 0; k < 4000; k++) begin
      rand_inputs();
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
